// File: rtl/tq_pkg.sv
// Shared definitions for the rec_tq transpose path.
// Holds the coefficient/lane geometry, block-size encodings, the size-to-dimension
// helper and the single-bank state encoding used by tq_transpose_buf.
package tq_pkg;

  localparam int DATA_W = 28;
  localparam int LANES  = 32;

  localparam logic [1:0] TQ_SIZE_4  = 2'd0;
  localparam logic [1:0] TQ_SIZE_8  = 2'd1;
  localparam logic [1:0] TQ_SIZE_16 = 2'd2;
  localparam logic [1:0] TQ_SIZE_32 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } tq_state_e;

  // Block dimension N for a size code: 4 << size (4, 8, 16, 32).
  function automatic logic [5:0] size2n(input logic [1:0] size);
    return 6'd4 << size;
  endfunction

endpackage

// File: rtl/tq_transpose_bank.sv
// One N x N coefficient store (N <= LANES) with a row-write port and a
// column-read port.
// Ports:
//   clk      clock (the array is data only and carries no reset)
//   wr_en    write row wr_row this cycle
//   wr_row   row index being written
//   wr_n     block dimension of the row being written; lanes >= wr_n are not stored
//   wr_data  row data, lane k at [k*DATA_W +: DATA_W]
//   rd_col   column index being read
//   rd_n     block dimension of the stored block; lanes >= rd_n read as 0
//   rd_data  column data, lane r = element of row r
module tq_transpose_bank
  import tq_pkg::*;
(
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [4:0]              wr_row,
  input  logic [5:0]              wr_n,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic [4:0]              rd_col,
  input  logic [5:0]              rd_n,
  output logic [LANES*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [LANES][LANES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (k < int'(wr_n)) mem[wr_row][k] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < LANES; r++) begin
      if (r < int'(rd_n)) rd_data[r*DATA_W +: DATA_W] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/tq_transpose_buf.sv
// Transpose buffer between the row (first-pass) transform and the second-pass
// input of the shared DCT multiplexer. Rows of an N x N block are written one
// per cycle, then the block is emitted one column per cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid/o_ready     row handshake; i_size sampled on row 0 only
//   i_data              row, lane k at [k*DATA_W +: DATA_W]
//   o_valid/i_ready     column handshake (o_valid feeds the mux i_valid1)
//   o_data              column, lane r = row r element; lanes >= N are 0
//   o_size, o_last      size of the block being read, final-column marker
// Build option: TQ_TRANSPOSE_PINGPONG_EN selects two banks so that writing
// block k+1 overlaps reading block k; otherwise one bank with IDLE/WRITE/READ.
//
// Outputs are taken from flops (state, column counter, stored array) through
// the column mux only, so nothing on an input reaches an output in the same
// cycle. Holding rd_col under back-pressure therefore holds o_data as well.
module tq_transpose_buf
  import tq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [1:0]              i_size,
  input  logic [LANES*DATA_W-1:0] i_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic [1:0]              o_size,
  output logic                    o_last
);

  logic                    in_fire, out_fire;
  logic [1:0]              eff_size;
  logic [5:0]              eff_n, rd_n;
  logic                    row_last, col_last;
  logic [4:0]              wr_row_q, wr_row_d;
  logic [1:0]              wr_size_q, wr_size_d;
  logic [4:0]              rd_col_q, rd_col_d;
  logic [1:0]              rd_size;
  logic [LANES*DATA_W-1:0] rd_data;

  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  // Row 0 takes its size from the port; later rows use the latched size.
  assign eff_size = (wr_row_q == 5'd0) ? i_size : wr_size_q;
  assign eff_n    = size2n(eff_size);
  assign row_last = ({1'b0, wr_row_q} == (eff_n - 6'd1));
  assign rd_n     = size2n(rd_size);
  assign col_last = ({1'b0, rd_col_q} == (rd_n - 6'd1));

  assign o_size = rd_size;
  assign o_last = o_valid && col_last;
  assign o_data = o_valid ? rd_data : '0;

  always_comb begin
    wr_row_d  = wr_row_q;
    wr_size_d = wr_size_q;
    rd_col_d  = rd_col_q;
    if (in_fire) begin
      if (wr_row_q == 5'd0) wr_size_d = i_size;
      wr_row_d = row_last ? 5'd0 : wr_row_q + 5'd1;
    end
    if (out_fire) rd_col_d = col_last ? 5'd0 : rd_col_q + 5'd1;
  end

`ifdef TQ_TRANSPOSE_PINGPONG_EN
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0][1:0] bank_size_q, bank_size_d;
  logic [LANES*DATA_W-1:0] rd_data0, rd_data1;

  assign o_ready = !full_q[wr_bank_q];
  assign o_valid = full_q[rd_bank_q];
  assign rd_size = bank_size_q[rd_bank_q];
  assign rd_data = rd_bank_q ? rd_data1 : rd_data0;

  // A bank being written is never full and a bank being read always is, so a
  // completing write and a completing read in one cycle touch different banks.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    bank_size_d = bank_size_q;
    if (in_fire && row_last) begin
      full_d[wr_bank_q]      = 1'b1;
      bank_size_d[wr_bank_q] = eff_size;
      wr_bank_d              = ~wr_bank_q;
    end
    if (out_fire && col_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_size_q <= '0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_size_q <= bank_size_d;
    end
  end

  tq_transpose_bank u_bank0 (
    .clk     (clk),
    .wr_en   (in_fire && !wr_bank_q),
    .wr_row  (wr_row_q),
    .wr_n    (eff_n),
    .wr_data (i_data),
    .rd_col  (rd_col_q),
    .rd_n    (rd_n),
    .rd_data (rd_data0)
  );

  tq_transpose_bank u_bank1 (
    .clk     (clk),
    .wr_en   (in_fire && wr_bank_q),
    .wr_row  (wr_row_q),
    .wr_n    (eff_n),
    .wr_data (i_data),
    .rd_col  (rd_col_q),
    .rd_n    (rd_n),
    .rd_data (rd_data1)
  );
`else
  tq_state_e  state_q, state_d;
  logic [1:0] rd_size_q, rd_size_d;

  assign o_ready = (state_q != ST_READ);
  assign o_valid = (state_q == ST_READ);
  assign rd_size = rd_size_q;

  always_comb begin
    state_d   = state_q;
    rd_size_d = rd_size_q;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (in_fire) begin
          if (row_last) begin
            state_d   = ST_READ;
            rd_size_d = eff_size;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        if (out_fire && col_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_size_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      rd_size_q <= rd_size_d;
    end
  end

  tq_transpose_bank u_bank0 (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_row  (wr_row_q),
    .wr_n    (eff_n),
    .wr_data (i_data),
    .rd_col  (rd_col_q),
    .rd_n    (rd_n),
    .rd_data (rd_data)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row_q  <= 5'd0;
      wr_size_q <= 2'd0;
      rd_col_q  <= 5'd0;
    end else begin
      wr_row_q  <= wr_row_d;
      wr_size_q <= wr_size_d;
      rd_col_q  <= rd_col_d;
    end
  end

endmodule

// File: tb/tb_tq_transpose_buf.sv
// Testbench for tq_transpose_buf: random and directed blocks checked every
// cycle against a block-level transpose model, plus literal spot values.
`timescale 1ns/1ps
module tb_tq_transpose_buf;
  import tq_pkg::*;

  localparam int W = LANES*DATA_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [1:0]   i_size = 2'd0;
  logic [W-1:0] i_data = '0;
  logic         o_ready, o_valid, o_last;
  logic [1:0]   o_size;
  logic [W-1:0] o_data;

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 0;  // 0: i_ready high, 1: random, 2: driven by the sequence

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   sz;
    logic         last;
  } col_t;

  col_t              exp_q[$];
  int                blocks_pend = 0;
  int                m_row = 0;
  int                m_n = 4;
  logic [1:0]        m_sz = 2'd0;
  logic [DATA_W-1:0] m_mem [LANES][LANES];

  always #5 clk = ~clk;

  tq_transpose_buf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_size  (i_size),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_size  (o_size),
    .o_last  (o_last)
  );

  // Blocks completely written but not yet fully read; capacity is the bank count.
  function automatic bit rdy_exp();
`ifdef TQ_TRANSPOSE_PINGPONG_EN
    return blocks_pend < 2;
`else
    return blocks_pend == 0;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] lane(input logic [W-1:0] v, input int l);
    return v[l*DATA_W +: DATA_W];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    int bad;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      bad = -1;
      for (int l = LANES-1; l >= 0; l--)
        if (act[l*DATA_W +: DATA_W] !== exp[l*DATA_W +: DATA_W]) bad = l;
      $display("FAIL %s: lane %0d got %0h expected %0h at %0t", nm, bad,
               lane(act, bad), lane(exp, bad), $time);
    end
  endtask

  // Model: accept rows by the handshake rules, then queue the N columns of the
  // transposed block; pop a column whenever a transfer out takes place.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      blocks_pend = 0;
      m_row = 0;
    end else begin
      bit ovld, rdy;
      ovld = exp_q.size() > 0;
      rdy  = rdy_exp();
      if (ovld && i_ready) begin
        if (exp_q[0].last) blocks_pend--;
        void'(exp_q.pop_front());
      end
      if (i_valid && rdy) begin
        if (m_row == 0) begin
          m_sz = i_size;
          m_n  = 4 << i_size;
        end
        for (int k = 0; k < m_n; k++) m_mem[m_row][k] = i_data[k*DATA_W +: DATA_W];
        m_row++;
        if (m_row == m_n) begin
          for (int c = 0; c < m_n; c++) begin
            col_t e;
            e.d = '0;
            for (int r = 0; r < m_n; r++) e.d[r*DATA_W +: DATA_W] = m_mem[r][c];
            e.sz   = m_sz;
            e.last = (c == m_n-1);
            exp_q.push_back(e);
          end
          blocks_pend++;
          m_row = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_valid", o_valid, exp_q.size() > 0);
      chk("o_ready", o_ready, rdy_exp());
      if (o_valid && exp_q.size() > 0) begin
        chk_data("o_data", o_data, exp_q[0].d);
        chk("o_size", o_size, exp_q[0].sz);
        chk("o_last", o_last, exp_q[0].last);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0) i_ready = 1'b1;
    else if (rdy_mode == 1) i_ready = 1'($urandom_range(0, 1));
  end

  // mode 0: 16r+c, 1: -(32r+c), 2: random. Lanes >= N always carry junk.
  task automatic send_block(input logic [1:0] sz, input int mode, input int row1_sz,
                            input int r_first, input int r_end, input bit gaps,
                            input bit hold);
    int n;
    int tmo;
    bit acc;
    n = 4 << sz;
    for (int r = r_first; r < n && r < r_end; r++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        i_valid = 1'b0; @(posedge clk); #1;
      end
      i_valid = 1'b1;
      if (r == 0) i_size = sz;
      else if (r == 1 && row1_sz >= 0) i_size = 2'(row1_sz);
      else i_size = 2'($urandom);
      for (int k = 0; k < LANES; k++)
        i_data[k*DATA_W +: DATA_W] = (k >= n)    ? DATA_W'($urandom) :
                                     (mode == 0) ? DATA_W'(16*r + k) :
                                     (mode == 1) ? DATA_W'(-(r*32 + k)) :
                                                   DATA_W'($urandom);
      tmo = 0;
      do begin
        acc = o_ready;
        @(posedge clk); #1;
        tmo++;
      end while (!acc && tmo < 200);
      if (!acc) begin
        n_chk++; n_fail++;
        $display("FAIL row_accept_timeout: row %0d not accepted, o_ready %0b", r, o_ready);
      end
    end
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_after_drain", o_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] held;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_ready", o_ready, 1'b1);
    chk("rst_o_valid", o_valid, 1'b0);
    chk_data("rst_o_data", o_data, '0);
    chk("rst_o_size", o_size, 2'd0);
    chk("rst_o_last", o_last, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4x4, element (r,c) = 16r+c
    rdy_mode = 0;
    send_block(2'd0, 0, -1, 0, 99, 1'b0, 1'b0);
    chk("t4_c0_valid", o_valid, 1'b1);
    chk("t4_c0_lane1", lane(o_data, 1), 28'd16);
    chk("t4_c0_lane3", lane(o_data, 3), 28'd48);
    chk("t4_c0_lane4", lane(o_data, 4), 28'd0);
    chk("t4_c0_last", o_last, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t4_c3_last", o_last, 1'b1);
    chk("t4_c3_lane2", lane(o_data, 2), 28'd35);
    drain();

    // 32x32 negative values; column 0 must appear right after row 31
    send_block(2'd3, 1, -1, 0, 31, 1'b0, 1'b1);
    chk("t32_pre_valid", o_valid, 1'b0);
    send_block(2'd3, 1, -1, 31, 32, 1'b0, 1'b0);
    chk("t32_c0_valid", o_valid, 1'b1);
    chk("t32_c0_lane3", lane(o_data, 3), 28'hFFFFFA0);
    chk("t32_c0_lane31", lane(o_data, 31), 28'hFFFFC20);
    chk("t32_c0_size", o_size, 2'd3);
    drain();

    // 8x8 with back-pressure at column 2
    rdy_mode = 2;
    i_ready = 1'b1;
    send_block(2'd1, 2, -1, 0, 8, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    held = o_data;
    repeat (3) begin
      @(posedge clk); #1;
      chk_data("bp_hold_data", o_data, held);
      chk("bp_hold_last", o_last, 1'b0);
      chk("bp_hold_valid", o_valid, 1'b1);
    end
    i_ready = 1'b1;
    rdy_mode = 0;
    drain();

    // i_valid held through the read; then row0 size 8x8, row1 claims 32x32
    send_block(2'd1, 2, -1, 0, 8, 1'b0, 1'b1);
`ifndef TQ_TRANSPOSE_PINGPONG_EN
    chk("sb_ready_in_read", o_ready, 1'b0);
`endif
    send_block(2'd1, 2, 3, 0, 8, 1'b0, 1'b0);
`ifndef TQ_TRANSPOSE_PINGPONG_EN
    chk("sb_size_ignored", o_size, 2'd1);
`endif
    drain();

    // reset at row 5 of a 16x16 block, after a 32x32 block left o_size set
    send_block(2'd3, 2, -1, 0, 32, 1'b0, 1'b0);
    drain();
    send_block(2'd2, 2, -1, 0, 5, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_ready", o_ready, 1'b1);
    chk("mid_rst_o_valid", o_valid, 1'b0);
    chk_data("mid_rst_o_data", o_data, '0);
    chk("mid_rst_o_size", o_size, 2'd0);
    chk("mid_rst_o_last", o_last, 1'b0);
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(2'd0, 2, -1, 0, 4, 1'b0, 1'b0);
    drain();

    // random sizes, gaps and back-pressure
    rdy_mode = 1;
    for (int b = 0; b < 8; b++)
      send_block(2'($urandom_range(0, 3)), 2, -1, 0, 32, 1'b1, 1'b0);
    drain();
    rdy_mode = 0;

`ifdef TQ_TRANSPOSE_PINGPONG_EN
    // back-to-back 16x16: 32 consecutive valid columns, A then B
    @(posedge clk); #1;
    send_block(2'd2, 2, -1, 0, 16, 1'b0, 1'b1);
    fork
      send_block(2'd2, 2, -1, 0, 16, 1'b0, 1'b0);
      begin
        for (int c = 0; c < 32; c++) begin
          chk("pp_continuous_valid", o_valid, 1'b1);
          @(posedge clk); #1;
        end
      end
    join
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
